// File: rtl/vga_sync_tracker.sv
// Recovers x/y pixel coordinates from a negative-polarity VGA sync pair.
// Counts in phase with the sync edges and drops lock on any timing violation.
module vga_sync_tracker #(
    parameter int HA_END     = 639,
    parameter int HS_STA     = 655,
    parameter int HS_END     = 751,
    parameter int LINE       = 799,
    parameter int VA_END     = 479,
    parameter int VS_STA     = 489,
    parameter int SCREEN     = 524,
    parameter int LOCK_LINES = 2,
    parameter int TIMEOUT    = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam int GW = $clog2(LOCK_LINES + 1);

    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LINES);
    localparam logic [9:0]    HA_X     = 10'(HA_END);
    localparam logic [9:0]    HS_STA_X = 10'(HS_STA);
    localparam logic [9:0]    HS_NXT_X = 10'(HS_STA + 1);
    localparam logic [9:0]    HS_END_X = 10'(HS_END);
    localparam logic [9:0]    LINE_X   = 10'(LINE);
    localparam logic [9:0]    VA_Y     = 10'(VA_END);
    localparam logic [9:0]    VS_STA_Y = 10'(VS_STA);
    localparam logic [9:0]    SCREEN_Y = 10'(SCREEN);
    localparam logic [10:0]   WD_EXP   = 11'(TIMEOUT - 1);

    logic          h_prev;
    logic          v_prev;
    logic          h_fall;
    logic          h_rise;
    logic          v_fall;
    logic [9:0]    x_n;
    logic [9:0]    y_n;
    logic [GW-1:0] h_good;
    logic [GW-1:0] h_good_n;
    logic          v_ok;
    logic          v_ok_n;
    logic          v_pass;
    logic          h_bad;
    logic          v_bad;
    logic [10:0]   wd;
    logic [10:0]   wd_n;
    logic          wd_exp;

    always_comb begin
        h_fall = h_prev & ~h_sync;
        h_rise = ~h_prev & h_sync;
        v_fall = v_prev & ~v_sync;

        // h_fall realigns x to the pixel after the expected fall position
        x_n = x + 10'd1;
        y_n = y;
        if (h_fall) begin
            x_n = HS_NXT_X;
        end else if (x == LINE_X) begin
            x_n = '0;
            y_n = (y == SCREEN_Y) ? '0 : y + 10'd1;
        end
        if (v_fall) begin
            y_n = VS_STA_Y;
        end

        wd_exp = !h_fall && (wd == WD_EXP);
        wd_n   = h_fall ? '0 : ((&wd) ? wd : wd + 11'd1);

        h_bad = (h_fall && (x != HS_STA_X)) ||
                (h_rise && (x != HS_END_X));

        h_good_n = h_good;
        if (h_fall && (x == HS_STA_X) && (h_good != GOOD_MAX)) begin
            h_good_n = h_good + 1'b1;
        end
        if (h_bad || wd_exp) begin
            h_good_n = '0;
        end

        // first aligned v edge is accepted; later ones must match y
        v_pass = (x == '0) && (!v_ok || (y == VS_STA_Y));
        v_bad  = v_fall && !v_pass;

        v_ok_n = v_ok;
        if (v_fall) begin
            v_ok_n = v_pass;
        end
        if (wd_exp) begin
            v_ok_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_prev   <= 1'b1;
            v_prev   <= 1'b1;
            x        <= '0;
            y        <= '0;
            h_good   <= '0;
            v_ok     <= 1'b0;
            wd       <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            h_prev   <= h_sync;
            v_prev   <= v_sync;
            x        <= x_n;
            y        <= y_n;
            h_good   <= h_good_n;
            v_ok     <= v_ok_n;
            wd       <= wd_n;
            locked   <= (h_good_n == GOOD_MAX) && v_ok_n;
            sync_err <= locked && (h_bad || v_bad || wd_exp);
        end
    end

    assign display     = locked && (x <= HA_X) && (y <= VA_Y);
    assign frame_start = locked && (x == '0) && (y == '0);

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Randomized-phase VGA transmitter model driving vga_sync_tracker,
// with scenario-level timing expectations and per-cycle x/y tracking.
module tb_vga_sync_tracker;

    localparam int HA_END     = 39;
    localparam int HS_STA     = 47;
    localparam int HS_END     = 55;
    localparam int LINE       = 63;
    localparam int VA_END     = 29;
    localparam int VS_STA     = 33;
    localparam int SCREEN     = 39;
    localparam int LOCK_LINES = 2;
    localparam int TIMEOUT    = 128;
    localparam int H_TOT      = LINE + 1;
    localparam int FRAME      = H_TOT * (SCREEN + 1);
    localparam int ACT        = (HA_END + 1) * (VA_END + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       h_sync = 1'b1;
    logic       v_sync = 1'b1;
    logic [9:0] x;
    logic [9:0] y;
    logic       display;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    vga_sync_tracker #(
        .HA_END(HA_END), .HS_STA(HS_STA), .HS_END(HS_END),
        .LINE(LINE), .VA_END(VA_END), .VS_STA(VS_STA),
        .SCREEN(SCREEN), .LOCK_LINES(LOCK_LINES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
        .x(x), .y(y), .display(display), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_x, tx_y;
    bit track = 0;
    int s_x, s_y;
    logic s_lock, s_err, s_disp, s_fs;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    logic was_locked = 1'b0;
    int err_cnt, first_err, first_unlock;
    int hfalls = 0, vfalls = 0;
    int last_hfall = -1, last_hrise = -1, last_vfall = -1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                         tag, got, exp, cyc);
        end
    endtask

    function automatic logic nom_h(input int xx);
        return !(xx >= HS_STA && xx < HS_END);
    endfunction

    function automatic logic nom_v(input int yy);
        return !(yy >= VS_STA && yy <= VS_STA + 1);
    endfunction

    task automatic clr_events();
        err_cnt = 0;
        first_err = -1;
        first_unlock = -1;
    endtask

    // One pixel: drive the levels, observe the registered state, advance.
    task automatic tick(input logic hs, input logic vs);
        @(negedge clk);
        h_sync = hs;
        v_sync = vs;
        #1;
        cyc++;
        s_x = int'(x);
        s_y = int'(y);
        s_lock = locked;
        s_err = sync_err;
        s_disp = display;
        s_fs = frame_start;
        if (track) begin
            check("x", x, tx_x);
            check("y", y, tx_y);
            check("locked", locked, 1);
            check("sync_err", sync_err, 0);
            check("display", display,
                  (tx_x <= HA_END && tx_y <= VA_END) ? 1 : 0);
            check("frame_start", frame_start,
                  (tx_x == 0 && tx_y == 0) ? 1 : 0);
        end
        if (sync_err === 1'b1) begin
            err_cnt++;
            if (first_err < 0) first_err = cyc;
        end
        if (was_locked && locked !== 1'b1 && first_unlock < 0)
            first_unlock = cyc;
        was_locked = (locked === 1'b1);
        if (prev_hs && !hs) begin hfalls++; last_hfall = cyc; end
        if (!prev_hs && hs) last_hrise = cyc;
        if (prev_vs && !vs) begin vfalls++; last_vfall = cyc; end
        prev_hs = hs;
        prev_vs = vs;
        if (tx_x == LINE) begin
            tx_x = 0;
            tx_y = (tx_y == SCREEN) ? 0 : tx_y + 1;
        end else begin
            tx_x++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick(nom_h(tx_x), nom_v(tx_y));
    endtask

    task automatic go_to(input int xx, input int yy);
        for (int k = 0; k < FRAME && !(tx_x == xx && tx_y == yy); k++)
            run(1);
    endtask

    task automatic until_hf(input string tag, input int target);
        for (int k = 0; k < 8 * H_TOT && hfalls < target; k++) run(1);
        check(tag, (hfalls >= target) ? 1 : 0, 1);
    endtask

    task automatic until_vf(input string tag);
        int v0;
        v0 = vfalls;
        for (int k = 0; k < 2 * FRAME && vfalls == v0; k++) run(1);
        check(tag, (vfalls > v0) ? 1 : 0, 1);
    endtask

    // Lock must be seen before the max_vf-th v_fall after the call.
    task automatic wait_lock(input string tag, input int max_vf);
        int v0;
        v0 = vfalls;
        for (int k = 0; k < 4 * FRAME && s_lock !== 1'b1 &&
             vfalls < v0 + max_vf; k++)
            run(1);
        check(tag, s_lock, 1);
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, "_x"}, s_x, 0);
        check({tag, "_y"}, s_y, 0);
        check({tag, "_locked"}, s_lock, 0);
        check({tag, "_sync_err"}, s_err, 0);
        check({tag, "_display"}, s_disp, 0);
        check({tag, "_frame_start"}, s_fs, 0);
    endtask

    initial begin
        int bad, t0, hf0, fs_cnt, disp_cnt, last_fs;

        tx_x = $urandom_range(0, LINE);
        tx_y = $urandom_range(0, SCREEN);

        // reset, then lock from an arbitrary phase
        run(3);
        reset_state_checks("reset");
        rst = 1'b0;
        wait_lock("initial_lock", 3);
        track = 1;
        run(3 * FRAME);

        // frame_start once per frame, display count per frame
        go_to(0, 0);
        fs_cnt = 0;
        disp_cnt = 0;
        last_fs = -1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            run(1);
            if (s_fs === 1'b1) begin
                fs_cnt++;
                if (last_fs >= 0) check("fs_gap", cyc - last_fs, FRAME);
                last_fs = cyc;
            end
            if (s_disp === 1'b1) disp_cnt++;
        end
        check("fs_count", fs_cnt, 2);
        check("display_count", disp_cnt, 2 * ACT);

        // one h pulse delayed by 3 pixels
        go_to(0, 2);
        track = 0;
        clr_events();
        repeat (H_TOT)
            tick(!(tx_x >= HS_STA + 3 && tx_x < HS_END + 3), nom_v(tx_y));
        bad = last_hfall;
        hf0 = hfalls;
        until_hf("dly_falls", hf0 + LOCK_LINES + 1);
        check("dly_not_early", s_lock, 0);
        run(1);
        check("dly_relock", s_lock, 1);
        check("dly_err_at", first_err, bad + 1);
        check("dly_unlock_at", first_unlock, bad + 1);
        check("dly_err_count", err_cnt, 1);
        track = 1;
        run(2 * H_TOT);

        // h_sync held high until the watchdog fires
        go_to(0, 5);
        track = 0;
        clr_events();
        t0 = last_hfall;
        repeat (3 * H_TOT) tick(1'b1, nom_v(tx_y));
        check("wd_err_at", first_err, t0 + TIMEOUT + 1);
        check("wd_unlock_at", first_unlock, t0 + TIMEOUT + 1);
        check("wd_err_count", err_cnt, 1);
        until_vf("wd_vfall");
        check("wd_not_early", s_lock, 0);
        run(1);
        check("wd_relock", s_lock, 1);
        track = 1;
        run(2 * H_TOT);

        // h pulse one pixel short: early rise
        go_to(0, 12);
        track = 0;
        clr_events();
        repeat (H_TOT)
            tick(!(tx_x >= HS_STA && tx_x < HS_END - 1), nom_v(tx_y));
        bad = last_hrise;
        hf0 = hfalls;
        until_hf("narrow_falls", hf0 + LOCK_LINES);
        check("narrow_not_early", s_lock, 0);
        run(1);
        check("narrow_relock", s_lock, 1);
        check("narrow_err_at", first_err, bad + 1);
        check("narrow_unlock_at", first_unlock, bad + 1);
        track = 1;
        run(H_TOT);

        // spurious v_fall at x=5
        go_to(0, 16);
        track = 0;
        clr_events();
        repeat (H_TOT)
            tick(nom_h(tx_x), (tx_x >= 5 && tx_x < 10) ? 1'b0 : nom_v(tx_y));
        bad = last_vfall;
        check("vinj_err_at", first_err, bad + 1);
        check("vinj_unlock_at", first_unlock, bad + 1);
        check("vinj_err_count", err_cnt, 1);
        until_vf("vinj_vfall");
        check("vinj_not_early", s_lock, 0);
        run(1);
        check("vinj_relock", s_lock, 1);
        track = 1;
        run(FRAME);

        // one-cycle reset while locked
        go_to(20, 7);
        track = 0;
        clr_events();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        reset_state_checks("midrst");
        check("midrst_err_count", err_cnt, 0);
        wait_lock("midrst_relock", 3);
        track = 1;
        run(FRAME);
        track = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: cycle %0d reached time limit", cyc);
        $fatal(1);
    end

endmodule
